blob_extent_tracker: RTL and testbench
======================================

BLOB_EXTENT_TRACKER -- requirements
Module: blob_extent_tracker

Interface
REQ-001 Parameter H_ACTIVE, default 1024: active pixels per line; hits with hcount >= H_ACTIVE are ignored.
REQ-002 Parameter V_ACTIVE, default 768: active lines per frame; frame end is detected when vcount reaches V_ACTIVE.
REQ-003 Parameter MIN_PIXELS, default 64: minimum qualified hit count for a frame to be reported as found.
REQ-004 Parameter SMOOTH, default 0: 1 = new x/y are averaged with previous x/y; 0 = raw.
REQ-005 clock  input  1  single system clock; all state is updated on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 hcount  input  11  current pixel column from the VGA timing generator.
REQ-008 vcount  input  10  current pixel row from the VGA timing generator.
REQ-009 pixel_hit  input  1  the colour-threshold match for the pixel at (hcount, vcount).
REQ-010 x  output  11  bounding-box centre column; feeds the box-overlay stage.
REQ-011 y  output  10  bounding-box centre row.
REQ-012 width  output  11  xmax - xmin of the last found frame.
REQ-013 height  output  10  ymax - ymin of the last found frame.
REQ-014 found  output  1  1 = the last completed frame had hit count >= MIN_PIXELS.
REQ-015 valid  output  1  one-cycle pulse at every frame report, whether or not the blob is found.

Function
REQ-016 The FSM SHALL have three states: WAIT_FRAME, SCAN, REPORT.
REQ-017 WAIT_FRAME -> SCAN on the cycle where hcount==0 and vcount==0; in that cycle the accumulators SHALL be initialised: xmin=all-ones, ymin=all-ones, xmax=0, ymax=0, count=0.
REQ-018 A qualified hit is pixel_hit & (hcount<H_ACTIVE) & (vcount<V_ACTIVE).
REQ-019 A qualified hit in the frame-start cycle SHALL be included, so a hit at (0,0) gives min=max=0 and count=1.
REQ-020 In SCAN, each qualified hit SHALL update xmin/xmax/ymin/ymax with unsigned compares and increment count (20 bits, saturating at 2^20-1).
REQ-021 SCAN -> REPORT on the first cycle with vcount==V_ACTIVE; hits in that cycle are not qualified.
REQ-022 In REPORT, if count >= MIN_PIXELS: width=xmax-xmin; height=ymax-ymin; cx=(xmin+xmax)>>1 and cy=(ymin+ymax)>>1, each computed with 1 extra bit; found=1.
REQ-023 In REPORT, if count >= MIN_PIXELS and SMOOTH=1: x=(x+cx)>>1 and y=(y+cy)>>1, each with 1 extra bit; otherwise x=cx and y=cy.
REQ-024 In REPORT, if count < MIN_PIXELS: x, y, width and height SHALL hold their previous values, and found=0.
REQ-025 valid SHALL be 1 for exactly the cycle after REPORT is entered, with x/y/width/height/found already updated in that cycle; REPORT -> WAIT_FRAME unconditionally after one cycle.
REQ-026 Outputs SHALL be registered and change only at a REPORT update, giving one report per frame; latency from frame end to valid is 2 cycles.
REQ-027 The overlay stage reads width>>1 as the half-extent, so width/height SHALL be full extents, not half extents.

Reset
REQ-028 While reset=1: state=WAIT_FRAME; x=0, y=0, width=0, height=0, found=0, valid=0; accumulators cleared.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; accumulation resumes only at the next (0,0) frame start.

Structure
REQ-030 A shared package SHALL hold H_W=11, V_W=10, CNT_W=20 and the state-encoding typedef.
REQ-031 The natural sub-module is axis_extent: one axis min/max register pair with clear and hit inputs, instantiated twice (H_W, V_W).

Verification
REQ-032 Single pixel hit at (100,50) with MIN_PIXELS=1 -> valid pulse; x=100, y=50, width=0, height=0, found=1.
REQ-033 10x10 filled square at cols 200-209 and rows 300-309 -> x=204, y=304, width=9, height=9, found=1, count=100.
REQ-034 30 scattered hits with MIN_PIXELS=64 after a found frame -> found=0; x/y/width/height unchanged; valid still pulses once.
REQ-035 Hits at hcount=1030 and at vcount=768 only -> found=0; no extent change.
REQ-036 SMOOTH=1: previous x=100, new blob centre 200 -> x=150.
REQ-037 Reset pulse at vcount=400 of a frame with hits -> all outputs 0; the next full frame reports only that frame's hits.

Source files
------------

// File: rtl/blob_extent_tracker_pkg.sv
// Shared widths and FSM state encoding for the blob extent tracker.
//   H_W   : horizontal coordinate width (hcount, x, width)
//   V_W   : vertical coordinate width (vcount, y, height)
//   CNT_W : qualified-hit counter width (saturating)
package blob_extent_tracker_pkg;

  localparam int H_W   = 11;
  localparam int V_W   = 10;
  localparam int CNT_W = 20;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    SCAN       = 2'd1,
    REPORT     = 2'd2
  } state_t;

endpackage

// File: rtl/blob_extent_tracker_axis.sv
// One-axis extent accumulator: running min/max of hit coordinates.
// Ports:
//   i_clk   : clock
//   i_rst   : asynchronous active-high reset (returns to the empty state)
//   i_clear : restart accumulation; a hit in the same cycle seeds min=max=coord
//   i_hit   : coordinate is a qualified hit
//   i_coord : coordinate on this axis
//   o_min   : smallest hit coordinate since clear (all-ones when empty)
//   o_max   : largest hit coordinate since clear (zero when empty)
module axis_extent #(
  parameter int unsigned W = 11
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_hit,
  input  logic [W-1:0] i_coord,
  output logic [W-1:0] o_min,
  output logic [W-1:0] o_max
);

  logic [W-1:0] r_min;
  logic [W-1:0] r_max;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_min <= '1;
      r_max <= '0;
    end else if (i_clear) begin
      // Start-of-frame hit is folded into the fresh extent directly.
      if (i_hit) begin
        r_min <= i_coord;
        r_max <= i_coord;
      end else begin
        r_min <= '1;
        r_max <= '0;
      end
    end else if (i_hit) begin
      if (i_coord < r_min) r_min <= i_coord;
      if (i_coord > r_max) r_max <= i_coord;
    end
  end

  assign o_min = r_min;
  assign o_max = r_max;

endmodule

// File: rtl/blob_extent_tracker.sv
// Per-frame bounding box of colour-threshold hits from a VGA raster.
// Accumulates min/max column and row of qualified hits over each frame and
// reports the box centre and full extents once per frame.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   hcount       : current pixel column
//   vcount       : current pixel row
//   pixel_hit    : colour match for the pixel at (hcount, vcount)
//   x, y         : registered box centre (optionally smoothed)
//   width,height : full extents (max - min) of the last found frame
//   found        : last completed frame had at least MIN_PIXELS hits
//   valid        : one-cycle pulse at every frame report
module blob_extent_tracker
  import blob_extent_tracker_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 1024,
  parameter int unsigned V_ACTIVE   = 768,
  parameter int unsigned MIN_PIXELS = 64,
  parameter int unsigned SMOOTH     = 0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [H_W-1:0] hcount,
  input  logic [V_W-1:0] vcount,
  input  logic           pixel_hit,
  output logic [H_W-1:0] x,
  output logic [V_W-1:0] y,
  output logic [H_W-1:0] width,
  output logic [V_W-1:0] height,
  output logic           found,
  output logic           valid
);

  // One extra bit so active sizes up to the full coordinate range compare cleanly.
  localparam logic [H_W:0]     LP_H_ACT = H_ACTIVE[H_W:0];
  localparam logic [V_W:0]     LP_V_ACT = V_ACTIVE[V_W:0];
  localparam logic [CNT_W-1:0] LP_MIN   = MIN_PIXELS[CNT_W-1:0];

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [H_W-1:0]   r_x;
  logic [V_W-1:0]   r_y;
  logic [H_W-1:0]   r_width;
  logic [V_W-1:0]   r_height;
  logic             r_found;
  logic             r_valid;

  logic           w_frame_start;
  logic           w_frame_end;
  logic           w_qual;
  logic           w_clear;
  logic           w_acc_hit;
  logic           w_found;
  logic [H_W-1:0] w_xmin;
  logic [H_W-1:0] w_xmax;
  logic [V_W-1:0] w_ymin;
  logic [V_W-1:0] w_ymax;
  logic [H_W:0]   w_xsum;
  logic [V_W:0]   w_ysum;
  logic [H_W-1:0] w_cx;
  logic [V_W-1:0] w_cy;
  logic [H_W:0]   w_xavg_sum;
  logic [V_W:0]   w_yavg_sum;
  logic [H_W-1:0] w_x_next;
  logic [V_W-1:0] w_y_next;

  assign w_frame_start = (hcount == '0) && (vcount == '0);
  assign w_frame_end   = ({1'b0, vcount} == LP_V_ACT);
  assign w_qual        = pixel_hit && ({1'b0, hcount} < LP_H_ACT)
                                   && ({1'b0, vcount} < LP_V_ACT);

  // Accumulators restart on the frame-start cycle and take hits only while scanning.
  assign w_clear   = (r_state == WAIT_FRAME) && w_frame_start;
  assign w_acc_hit = w_qual && (w_clear || ((r_state == SCAN) && !w_frame_end));

  axis_extent #(.W(H_W)) u_axis_h (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_clear (w_clear),
    .i_hit   (w_acc_hit),
    .i_coord (hcount),
    .o_min   (w_xmin),
    .o_max   (w_xmax)
  );

  axis_extent #(.W(V_W)) u_axis_v (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_clear (w_clear),
    .i_hit   (w_acc_hit),
    .i_coord (vcount),
    .o_min   (w_ymin),
    .o_max   (w_ymax)
  );

  assign w_found = (r_count >= LP_MIN);

  // Centres and averages keep the carry bit before halving.
  assign w_xsum     = {1'b0, w_xmin} + {1'b0, w_xmax};
  assign w_ysum     = {1'b0, w_ymin} + {1'b0, w_ymax};
  assign w_cx       = w_xsum[H_W:1];
  assign w_cy       = w_ysum[V_W:1];
  assign w_xavg_sum = {1'b0, r_x} + {1'b0, w_cx};
  assign w_yavg_sum = {1'b0, r_y} + {1'b0, w_cy};
  assign w_x_next   = (SMOOTH != 0) ? w_xavg_sum[H_W:1] : w_cx;
  assign w_y_next   = (SMOOTH != 0) ? w_yavg_sum[V_W:1] : w_cy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= WAIT_FRAME;
      r_count  <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_width  <= '0;
      r_height <= '0;
      r_found  <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        WAIT_FRAME: begin
          if (w_frame_start) begin
            r_state <= SCAN;
            r_count <= {{(CNT_W-1){1'b0}}, w_qual};
          end
        end
        SCAN: begin
          if (w_frame_end) begin
            r_state <= REPORT;
          end else if (w_qual && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        REPORT: begin
          r_valid <= 1'b1;
          r_found <= w_found;
          if (w_found) begin
            r_x      <= w_x_next;
            r_y      <= w_y_next;
            r_width  <= w_xmax - w_xmin;
            r_height <= w_ymax - w_ymin;
          end
          r_state <= WAIT_FRAME;
        end
        default: r_state <= WAIT_FRAME;
      endcase
    end
  end

  assign x      = r_x;
  assign y      = r_y;
  assign width  = r_width;
  assign height = r_height;
  assign found  = r_found;
  assign valid  = r_valid;

endmodule

// File: tb/tb_blob_extent_tracker.sv
module tb_blob_extent_tracker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        pixel_hit = 1'b0;

  // u1: MIN_PIXELS=1 raw; u64: MIN_PIXELS=64 raw; us: MIN_PIXELS=1 smoothed
  logic [10:0] x1, w1, x64, w64, xs, ws;
  logic [9:0]  y1, h1, y64, h64, ys, hs;
  logic        f1, v1, f64, v64, fs, vs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  blob_extent_tracker #(.H_ACTIVE(1024), .V_ACTIVE(768), .MIN_PIXELS(1), .SMOOTH(0)) u1 (
    .clock(clock), .reset(reset), .hcount(hcount), .vcount(vcount), .pixel_hit(pixel_hit),
    .x(x1), .y(y1), .width(w1), .height(h1), .found(f1), .valid(v1));

  blob_extent_tracker #(.H_ACTIVE(1024), .V_ACTIVE(768), .MIN_PIXELS(64), .SMOOTH(0)) u64 (
    .clock(clock), .reset(reset), .hcount(hcount), .vcount(vcount), .pixel_hit(pixel_hit),
    .x(x64), .y(y64), .width(w64), .height(h64), .found(f64), .valid(v64));

  blob_extent_tracker #(.H_ACTIVE(1024), .V_ACTIVE(768), .MIN_PIXELS(1), .SMOOTH(1)) us (
    .clock(clock), .reset(reset), .hcount(hcount), .vcount(vcount), .pixel_hit(pixel_hit),
    .x(xs), .y(ys), .width(ws), .height(hs), .found(fs), .valid(vs));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // sel: 0 = u1, 1 = u64, 2 = us
  task automatic chk_rep(input string tag, input int sel, input int ex, input int ey,
                         input int ew, input int eh, input int ef);
    case (sel)
      0: begin
        chk({tag, ".u1.x"}, 32'(x1), ex);  chk({tag, ".u1.y"}, 32'(y1), ey);
        chk({tag, ".u1.w"}, 32'(w1), ew);  chk({tag, ".u1.h"}, 32'(h1), eh);
        chk({tag, ".u1.found"}, 32'(f1), ef);
      end
      1: begin
        chk({tag, ".u64.x"}, 32'(x64), ex);  chk({tag, ".u64.y"}, 32'(y64), ey);
        chk({tag, ".u64.w"}, 32'(w64), ew);  chk({tag, ".u64.h"}, 32'(h64), eh);
        chk({tag, ".u64.found"}, 32'(f64), ef);
      end
      default: begin
        chk({tag, ".us.x"}, 32'(xs), ex);  chk({tag, ".us.y"}, 32'(ys), ey);
        chk({tag, ".us.w"}, 32'(ws), ew);  chk({tag, ".us.h"}, 32'(hs), eh);
        chk({tag, ".us.found"}, 32'(fs), ef);
      end
    endcase
  endtask

  task automatic drive(input int h, input int v, input logic hit);
    @(negedge clock);
    hcount    = 11'(h);
    vcount    = 10'(v);
    pixel_hit = hit;
  endtask

  // Frame-end cycle carries a hit on vcount=768 that must be ignored.
  // Valid is low one cycle after frame end, high the next, then low again.
  task automatic end_frame(input string tag);
    drive(20, 768, 1'b1);
    drive(5, 769, 1'b0);
    chk({tag, ".valid_early"}, 32'(v1), 0);
    @(negedge clock);
    chk({tag, ".valid.u1"}, 32'(v1), 1);
    chk({tag, ".valid.u64"}, 32'(v64), 1);
    chk({tag, ".valid.us"}, 32'(vs), 1);
  endtask

  task automatic after_frame(input string tag);
    @(negedge clock);
    chk({tag, ".valid_drop.u1"}, 32'(v1), 0);
    chk({tag, ".valid_drop.u64"}, 32'(v64), 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    chk_rep("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.valid", 32'(v1), 0);
    reset = 1'b0;
    drive(5, 769, 1'b0);

    // F1: single hit at (100,50)
    drive(0, 0, 1'b0);
    drive(100, 50, 1'b1);
    end_frame("f1");
    chk_rep("f1", 0, 100, 50, 0, 0, 1);
    chk_rep("f1", 1, 0, 0, 0, 0, 0);
    chk_rep("f1", 2, 50, 25, 0, 0, 1);
    after_frame("f1");

    // F2: 10x10 square, cols 200-209, rows 300-309 (100 hits)
    drive(0, 0, 1'b0);
    for (int r = 300; r < 310; r++)
      for (int c = 200; c < 210; c++)
        drive(c, r, 1'b1);
    end_frame("f2");
    chk_rep("f2", 0, 204, 304, 9, 9, 1);
    chk_rep("f2", 1, 204, 304, 9, 9, 1);
    chk_rep("f2", 2, 127, 164, 9, 9, 1);
    after_frame("f2");

    // F3: 30 scattered hits, cols 10..213 step 7, rows 20..107 step 3
    drive(0, 0, 1'b0);
    for (int i = 0; i < 30; i++) drive(10 + 7 * i, 20 + 3 * i, 1'b1);
    end_frame("f3");
    chk_rep("f3", 0, 111, 63, 203, 87, 1);
    chk_rep("f3", 1, 204, 304, 9, 9, 0);
    chk_rep("f3", 2, 119, 113, 203, 87, 1);
    after_frame("f3");

    // F4: only out-of-range hits
    drive(0, 0, 1'b0);
    drive(1030, 5, 1'b1);
    drive(1500, 100, 1'b1);
    end_frame("f4");
    chk_rep("f4", 0, 111, 63, 203, 87, 0);
    chk_rep("f4", 1, 204, 304, 9, 9, 0);
    chk_rep("f4", 2, 119, 113, 203, 87, 0);
    after_frame("f4");

    // F5: hit in the frame-start cycle at (0,0) plus far corner (1023,767)
    drive(0, 0, 1'b1);
    drive(1023, 767, 1'b1);
    end_frame("f5");
    chk_rep("f5", 0, 511, 383, 1023, 767, 1);
    chk_rep("f5", 1, 204, 304, 9, 9, 0);
    chk_rep("f5", 2, 315, 248, 1023, 767, 1);
    after_frame("f5");

    // F6: exactly 64 hits on row 10
    drive(0, 0, 1'b0);
    for (int c = 0; c < 64; c++) drive(c, 10, 1'b1);
    end_frame("f6");
    chk_rep("f6", 0, 31, 10, 63, 0, 1);
    chk_rep("f6", 1, 31, 10, 63, 0, 1);
    chk_rep("f6", 2, 173, 129, 63, 0, 1);
    after_frame("f6");

    // F7: 63 hits on row 20 -> one short for u64
    drive(0, 0, 1'b0);
    for (int c = 0; c < 63; c++) drive(c, 20, 1'b1);
    end_frame("f7");
    chk_rep("f7", 0, 31, 20, 62, 0, 1);
    chk_rep("f7", 1, 31, 10, 63, 0, 0);
    chk_rep("f7", 2, 102, 74, 62, 0, 1);
    after_frame("f7");

    // F8: reset mid-frame at vcount=400
    drive(0, 0, 1'b0);
    drive(400, 200, 1'b1);
    drive(600, 300, 1'b1);
    drive(10, 400, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk_rep("midrst", 0, 0, 0, 0, 0, 0);
    chk_rep("midrst", 2, 0, 0, 0, 0, 0);
    chk("midrst.valid", 32'(v1), 0);
    @(negedge clock);
    reset = 1'b0;
    // Remainder of the aborted frame must not produce a report
    drive(700, 450, 1'b1);
    drive(20, 768, 1'b1);
    drive(5, 769, 1'b0);
    drive(5, 769, 1'b0);
    chk("midrst.novalid", 32'(v1), 0);
    drive(5, 769, 1'b0);
    chk("midrst.novalid2", 32'(v1), 0);
    chk_rep("midrst.hold", 0, 0, 0, 0, 0, 0);

    // F9: next full frame reports only its own hits
    drive(0, 0, 1'b0);
    drive(150, 60, 1'b1);
    drive(250, 70, 1'b1);
    end_frame("f9");
    chk_rep("f9", 0, 200, 65, 100, 10, 1);
    chk_rep("f9", 1, 0, 0, 0, 0, 0);
    chk_rep("f9", 2, 100, 32, 100, 10, 1);
    after_frame("f9");

    // F10: smoothing, previous x=100, new centre 200 -> 150
    drive(0, 0, 1'b0);
    drive(200, 80, 1'b1);
    end_frame("f10");
    chk_rep("f10", 0, 200, 80, 0, 0, 1);
    chk_rep("f10", 2, 150, 56, 0, 0, 1);
    after_frame("f10");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
